fetch_queue_stage: RTL

- Instruction-fetch front end that sits directly upstream of the decode/IR latch in the simple pipeline.
- Owns the fetch PC and issues reads to the synchronous instruction RAM, which returns data one cycle after the read.
- Buffers returned words in a small prefetch FIFO and hands {instruction, PC+1} to decode over a valid/ready handshake.
- Handles branch redirect (flush plus squash of the in-flight read), halt, and the front-panel step enable.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/fetch_queue_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the fetch front end and its prefetch FIFO.
package pipeline_pkg;

  localparam int INST_W = 16;
  localparam int AW = 16;
  localparam logic [AW-1:0] RESET_PC = 16'h0000;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [AW-1:0]     pc_plus_one;
  } fetch_entry_t;

  typedef logic [$clog2(DEPTH_DEF):0] occ_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [PW:0]  count
);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[PW-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch front end: owns the fetch PC, issues RAM reads under a
// credit limit, and hands buffered {inst, pc+1} entries to decode.
module fetch_queue_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = pipeline_pkg::AW,
  parameter logic [AW-1:0] RESET_PC = pipeline_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     halt,
  input  logic                     br_taken,
  input  logic [AW-1:0]            br_target,
  output logic                     imem_rd,
  output logic [AW-1:0]            imem_addr,
  input  logic [15:0]              imem_q,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [15:0]              id_inst,
  output logic [AW-1:0]            id_pc_plus_one,
  output logic [AW-1:0]            fetch_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + AW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic          squash;
  logic          credit;
  logic          issue;
  logic          push;
  logic          pop;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;
  logic [CW-1:0] count;

  // Reserving a slot for the outstanding read means a return can always be pushed.
  assign credit = (count + CW'(inflight)) < DEPTH_C;
  assign issue  = !rst && ce && !halt && !br_taken && credit;
  assign push   = inflight && !squash && !br_taken && !rst;
  assign pop    = id_valid && id_ready && !br_taken;
  assign entry  = {imem_q, inflight_pc + AW'(1)};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc_q;
      if (br_taken)              squash <= inflight;
      else if (issue || inflight) squash <= 1'b0;
      if (br_taken)   pc_q <= br_target;
      else if (issue) pc_q <= pc_q + AW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (br_taken),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .count (count)
  );

  assign imem_rd        = issue;
  assign imem_addr      = pc_q;
  assign fetch_pc       = pc_q;
  assign occupancy      = count;
  assign id_valid       = (count != '0);
  assign id_inst        = id_valid ? head[EW-1:AW] : '0;
  assign id_pc_plus_one = id_valid ? head[AW-1:0] : '0;

endmodule
